// File: rtl/accel_lsu_port.sv
// rtl/accel_lsu_port.sv - accelerator load/store responder on the core data-memory bus (optional ACCEL_LSU_ALIGN_CHECK_EN)
module accel_lsu_port #(
    parameter logic [31:0] RESET_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        base_we,
    input  logic [1:0]  base_sel,
    input  logic [31:0] base_wdata,
    input  logic        lsu_ren,
    input  logic        lsu_wen,
    input  logic [1:0]  lsu_type,
    input  logic [31:0] lsu_addr_offset,
    input  logic [31:0] lsu_wdata,
    input  logic [1:0]  op_address_sel,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        busy,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i
);

    localparam logic [1:0] DATA_WORD = 2'b00;
    localparam logic [1:0] DATA_HALF = 2'b01;
    localparam logic [1:0] DATA_BYTE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] base_q [4];
    logic [31:0] base_d [4];
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  type_q, type_d;
    logic        we_q, we_d;
`ifdef ACCEL_LSU_ALIGN_CHECK_EN
    logic        err_q, err_d;
    logic        misaligned;
`endif

    logic [31:0] req_addr;
    logic [3:0]  be;
    logic [31:0] wdata_lanes;
    logic [31:0] rd_shift;
    logic [31:0] rd_ext;

    // Effective address of the request presented in IDLE, using the current (old) base
    always_comb begin
        req_addr = base_q[op_address_sel] + lsu_addr_offset;
`ifdef ACCEL_LSU_ALIGN_CHECK_EN
        misaligned = 1'b0;
        case (lsu_type)
            DATA_WORD: misaligned = (req_addr[1:0] != 2'b00);
            DATA_HALF: misaligned = req_addr[0];
            default:   misaligned = 1'b0;
        endcase
`else
        case (lsu_type)
            DATA_WORD: req_addr[1:0] = 2'b00;
            DATA_HALF: req_addr[0]   = 1'b0;
            default:   ;
        endcase
`endif
    end

    // Lane steering for the latched transaction
    always_comb begin
        rd_shift = data_rdata_i >> {addr_q[1:0], 3'b000};
        case (type_q)
            DATA_HALF: begin
                be          = 4'b0011 << addr_q[1:0];
                wdata_lanes = {2{wdata_q[15:0]}};
                rd_ext      = {16'h0000, rd_shift[15:0]};
            end
            DATA_BYTE: begin
                be          = 4'b0001 << addr_q[1:0];
                wdata_lanes = {4{wdata_q[7:0]}};
                rd_ext      = {24'h000000, rd_shift[7:0]};
            end
            default: begin
                be          = 4'b1111;
                wdata_lanes = wdata_q;
                rd_ext      = rd_shift;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        type_d  = type_q;
        we_d    = we_q;
`ifdef ACCEL_LSU_ALIGN_CHECK_EN
        err_d   = err_q;
`endif
        if (base_we) begin
            base_d[base_sel] = base_wdata;
        end
        case (state_q)
            S_IDLE: begin
                if (lsu_wen || lsu_ren) begin
                    addr_d  = req_addr;
                    type_d  = lsu_type;
                    wdata_d = lsu_wdata;
                    we_d    = lsu_wen;
                    rdata_d = 32'h0;
                    state_d = S_REQ;
`ifdef ACCEL_LSU_ALIGN_CHECK_EN
                    err_d   = misaligned;
                    // Misaligned accesses never touch the bus; any write is dropped
                    if (misaligned) begin
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_REQ: begin
                if (data_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (data_rvalid_i) begin
                    rdata_d = we_q ? 32'h0 : rd_ext;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            for (int i = 0; i < 4; i++) begin
                base_q[i] <= RESET_BASE;
            end
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            type_q  <= DATA_WORD;
            we_q    <= 1'b0;
`ifdef ACCEL_LSU_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            type_q  <= type_d;
            we_q    <= we_d;
`ifdef ACCEL_LSU_ALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Outputs decode from state only, so an asynchronous reset clears them at once
    assign data_req_o   = (state_q == S_REQ);
    assign data_we_o    = data_req_o & we_q;
    assign data_be_o    = data_req_o ? be : 4'b0000;
    assign data_addr_o  = data_req_o ? {addr_q[31:2], 2'b00} : 32'h0;
    assign data_wdata_o = data_we_o ? wdata_lanes : 32'h0;
    assign lsu_done     = (state_q == S_DONE);
    assign lsu_rdata    = lsu_done ? rdata_q : 32'h0;
    assign busy         = (state_q != S_IDLE);
`ifdef ACCEL_LSU_ALIGN_CHECK_EN
    assign lsu_err      = lsu_done & err_q;
`else
    assign lsu_err      = 1'b0;
`endif

endmodule

// File: tb/tb_accel_lsu_port.sv
// tb/tb_accel_lsu_port.sv - scoreboard bench for accel_lsu_port
module tb_accel_lsu_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        base_we;
    logic [1:0]  base_sel;
    logic [31:0] base_wdata;
    logic        lsu_ren, lsu_wen;
    logic [1:0]  lsu_type;
    logic [31:0] lsu_addr_offset, lsu_wdata;
    logic [1:0]  op_address_sel;
    logic        lsu_done, lsu_err, busy;
    logic [31:0] lsu_rdata;
    logic        data_req_o, data_gnt_i, data_rvalid_i, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;

    always #5 clk = ~clk;

    accel_lsu_port #(.RESET_BASE(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .base_we(base_we), .base_sel(base_sel), .base_wdata(base_wdata),
        .lsu_ren(lsu_ren), .lsu_wen(lsu_wen), .lsu_type(lsu_type),
        .lsu_addr_offset(lsu_addr_offset), .lsu_wdata(lsu_wdata),
        .op_address_sel(op_address_sel),
        .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err), .busy(busy),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_we_o(data_we_o), .data_be_o(data_be_o), .data_addr_o(data_addr_o),
        .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } done_t;

    bus_t        bus_q[$];
    done_t       done_q[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] base_m [4];

    int checks = 0;
    int failures = 0;
    int req_cycles = 0;
    int done_count = 0;

    bit          rsp_en = 1'b1;
    int          gnt_delay = 0, rv_delay = 0, gcnt = 0, rcnt = 0;
    logic [31:0] gnt_addr = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lo, input logic [1:0] typ);
        logic [31:0] sh;
        sh = w >> (8 * lo);
        if (typ == 2'b01) return sh & 32'h0000_FFFF;
        if (typ == 2'b10) return sh & 32'h0000_00FF;
        return sh;
    endfunction

    // Memory responder: drives grant/rvalid just after each rising edge
    initial begin
        data_gnt_i = 1'b0;
        data_rvalid_i = 1'b0;
        data_rdata_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_en) begin
                data_gnt_i = 1'b0;
                data_rvalid_i = 1'b0;
                if (data_req_o) begin
                    if (gcnt >= gnt_delay) begin
                        data_gnt_i = 1'b1;
                        gnt_addr = data_addr_o;
                        gcnt = 0;
                    end else begin
                        gcnt++;
                    end
                end else if (busy && !lsu_done) begin
                    if (rcnt >= rv_delay) begin
                        data_rvalid_i = 1'b1;
                        data_rdata_i = rd_word(gnt_addr);
                        rcnt = 0;
                    end else begin
                        rcnt++;
                    end
                end
            end
        end
    end

    logic        req_prev = 1'b0;
    logic [31:0] req_addr_prev = 32'h0;

    always @(negedge clk) begin
        bus_t  eb;
        done_t ed;
        if (data_req_o) begin
            req_cycles++;
            if (req_prev) check("req_addr_stable", data_addr_o, req_addr_prev);
        end
        req_prev = data_req_o;
        req_addr_prev = data_addr_o;
        if (data_req_o && data_gnt_i) begin
            if (bus_q.size() == 0) begin
                check("bus_unexpected", 32'd1, 32'd0);
            end else begin
                eb = bus_q.pop_front();
                check("bus_addr", data_addr_o, eb.addr);
                check("bus_be", {28'h0, data_be_o}, {28'h0, eb.be});
                check("bus_we", {31'h0, data_we_o}, {31'h0, eb.we});
                check("bus_wdata", data_wdata_o, eb.wdata);
            end
        end
        if (lsu_done) begin
            done_count++;
            if (done_q.size() == 0) begin
                check("done_unexpected", 32'd1, 32'd0);
            end else begin
                ed = done_q.pop_front();
                check("lsu_rdata", lsu_rdata, ed.rdata);
                check("lsu_err", {31'h0, lsu_err}, {31'h0, ed.err});
            end
        end
    end

    task automatic set_base(input logic [1:0] sel, input logic [31:0] val);
        base_we = 1'b1;
        base_sel = sel;
        base_wdata = val;
        @(posedge clk);
        #1;
        base_we = 1'b0;
        base_m[sel] = val;
    endtask

    // Presents one request while the DUT is IDLE; returns cycles from sampling to lsu_done
    task automatic do_req(input logic wr, input logic rd, input logic [1:0] typ, input logic [1:0] sel,
                          input logic [31:0] off, input logic [31:0] wd, input bit hold, output int lat);
        logic [31:0] a, wl, res;
        logic [3:0]  be;
        logic        mis;
        bit          got;
        a = base_m[sel] + off;
        mis = 1'b0;
`ifdef ACCEL_LSU_ALIGN_CHECK_EN
        mis = (typ == 2'b00 && a[1:0] != 2'b00) || (typ == 2'b01 && a[0]);
`else
        if (typ == 2'b00) a[1:0] = 2'b00;
        if (typ == 2'b01) a[0] = 1'b0;
`endif
        case (typ)
            2'b01:   begin be = 4'b0011 << a[1:0]; wl = {2{wd[15:0]}}; end
            2'b10:   begin be = 4'b0001 << a[1:0]; wl = {4{wd[7:0]}}; end
            default: begin be = 4'b1111; wl = wd; end
        endcase
        if (!mis) bus_q.push_back('{addr: {a[31:2], 2'b00}, be: be, we: wr, wdata: (wr ? wl : 32'h0)});
        res = (wr || mis) ? 32'h0 : extract(rd_word({a[31:2], 2'b00}), a[1:0], typ);
        done_q.push_back('{rdata: res, err: mis});
        lsu_wen = wr;
        lsu_ren = rd;
        lsu_type = typ;
        op_address_sel = sel;
        lsu_addr_offset = off;
        lsu_wdata = wd;
        lat = 0;
        got = 1'b0;
        while (lat < 40) begin
            @(negedge clk);
            if (lsu_done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (base_we) begin
                base_m[base_sel] = base_wdata;
                base_we = 1'b0;
            end
            lat++;
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (!hold) begin
            lsu_ren = 1'b0;
            lsu_wen = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, rc, dc;
        rst_n = 1'b0;
        base_we = 1'b0; base_sel = 2'd0; base_wdata = 32'h0;
        lsu_ren = 1'b0; lsu_wen = 1'b0; lsu_type = 2'b00;
        lsu_addr_offset = 32'h0; lsu_wdata = 32'h0; op_address_sel = 2'd0;
        for (int i = 0; i < 4; i++) base_m[i] = 32'h0;
        #12;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_req", {31'h0, data_req_o}, 32'h0);
        check("rst_done", {31'h0, lsu_done}, 32'h0);
        check("rst_be", {28'h0, data_be_o}, 32'h0);
        check("rst_addr", data_addr_o, 32'h0);
        check("rst_wdata", data_wdata_o, 32'h0);
        check("rst_rdata", lsu_rdata, 32'h0);
        check("rst_err", {31'h0, lsu_err}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Word read through base B
        set_base(2'd0, 32'h0000_1000);
        mem[32'h0000_1008] = 32'hDEAD_BEEF;
        do_req(1'b0, 1'b1, 2'b00, 2'd0, 32'h8, 32'h0, 1'b0, lat);
        check("lat_word_read", lat, 32'd3);

        // Byte write through Result base
        set_base(2'd3, 32'h0000_2000);
        do_req(1'b1, 1'b0, 2'b10, 2'd3, 32'h3, 32'h0000_00A5, 1'b0, lat);
        check("lat_byte_write", lat, 32'd3);

        // Half read with grant withheld three cycles
        mem[32'h0000_1000] = 32'h1234_ABCD;
        gnt_delay = 3;
        rc = req_cycles;
        do_req(1'b0, 1'b1, 2'b01, 2'd0, 32'h2, 32'h0, 1'b0, lat);
        check("lat_gnt_wait", lat, 32'd6);
        check("req_held_cycles", req_cycles - rc, 32'd4);
        gnt_delay = 0;

        // Byte read with rvalid withheld two cycles, half write on lane 2
        set_base(2'd1, 32'h0000_3000);
        rv_delay = 2;
        do_req(1'b0, 1'b1, 2'b10, 2'd1, 32'h1, 32'h0, 1'b0, lat);
        check("lat_rv_wait", lat, 32'd5);
        rv_delay = 0;
        do_req(1'b1, 1'b0, 2'b01, 2'd1, 32'h6, 32'h0000_BEEF, 1'b0, lat);

        // Multiplier-style fetch of eight words with ren held across done
        set_base(2'd2, 32'h0000_4000);
        rc = req_cycles;
        dc = done_count;
        for (int i = 0; i < 8; i++) begin
            do_req(1'b0, 1'b1, 2'b00, 2'd2, 32'(4 * i), 32'h0, (i < 7), lat);
            check("lat_fetch", lat, 32'd3);
            check("idle_after_done", {31'h0, busy}, 32'h0);
        end
        check("fetch_req_cycles", req_cycles - rc, 32'd8);
        check("fetch_done_count", done_count - dc, 32'd8);

        // Simultaneous ren/wen with a base write in the sampling cycle
        base_we = 1'b1;
        base_sel = 2'd0;
        base_wdata = 32'h0000_9000;
        do_req(1'b1, 1'b1, 2'b00, 2'd0, 32'h10, 32'h1122_3344, 1'b0, lat);
        check("lat_wen_prio", lat, 32'd3);
        do_req(1'b0, 1'b1, 2'b00, 2'd0, 32'h0, 32'h0, 1'b0, lat);

        // Asynchronous reset while waiting for rvalid
        rsp_en = 1'b0;
        bus_q.push_back('{addr: 32'h0000_9020, be: 4'b1111, we: 1'b0, wdata: 32'h0});
        lsu_ren = 1'b1; lsu_type = 2'b00; op_address_sel = 2'd0; lsu_addr_offset = 32'h20;
        @(posedge clk);
        #1;
        lsu_ren = 1'b0;
        data_gnt_i = 1'b1;
        @(posedge clk);
        #1;
        data_gnt_i = 1'b0;
        check("wait_busy", {31'h0, busy}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req", {31'h0, data_req_o}, 32'h0);
        check("arst_busy", {31'h0, busy}, 32'h0);
        check("arst_done", {31'h0, lsu_done}, 32'h0);
        check("arst_addr", data_addr_o, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) base_m[i] = 32'h0;
        dc = done_count;
        data_rvalid_i = 1'b1;
        data_rdata_i = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        data_rvalid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("late_rvalid_no_done", done_count - dc, 32'd0);
        check("late_rvalid_idle", {31'h0, busy}, 32'h0);
        gcnt = 0;
        rcnt = 0;
        rsp_en = 1'b1;

        // Misaligned word and half reads
        set_base(2'd0, 32'h0000_5000);
        mem[32'h0000_5000] = 32'hCAFE_F00D;
        rc = req_cycles;
        do_req(1'b0, 1'b1, 2'b00, 2'd0, 32'h2, 32'h0, 1'b0, lat);
`ifdef ACCEL_LSU_ALIGN_CHECK_EN
        check("misaligned_no_req", req_cycles - rc, 32'd0);
`else
        check("lat_misaligned_word", lat, 32'd3);
        do_req(1'b0, 1'b1, 2'b01, 2'd0, 32'h3, 32'h0, 1'b0, lat);
        check("lat_misaligned_half", lat, 32'd3);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("bus_q_drained", bus_q.size(), 32'd0);
        check("done_q_drained", done_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
